fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_fb_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Frame-buffer SDRAM arbiter: streams video line reads over Avalon-MM and
// slips in game-logic writes, with a starvation bound on pending writes.
module fb_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 160,
    parameter int MAX_OUT    = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_base,
    output logic              vid_busy,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              err
);

    localparam int CNT_W = $clog2(LINE_WORDS + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] LINE_C = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LINE_WORDS - 1);
    localparam logic [OUT_W-1:0] OUT_C  = OUT_W'(MAX_OUT);
    localparam logic [STV_W-1:0] STV_C  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VID  = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  base_r, base_s;
    logic [CNT_W-1:0]   issued_r, issued_s;
    logic [CNT_W-1:0]   returned_r, returned_s;
    logic [OUT_W-1:0]   outstanding_r, outstanding_s;
    logic [STV_W-1:0]   starve_r, starve_s;
    logic               busy_s;
    logic               rd_accept_s, wr_accept_s, rdv_ok_s, held_s, start_s;
    logic               rd_elig_s, wr_elig_s;
    logic               read_s, write_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [DATA_W-1:0]  wdata_s;

    assign rd_accept_s = (state_r == ST_VID) && !avm_waitrequest;
    assign wr_accept_s = (state_r == ST_WR) && !avm_waitrequest;
    assign held_s      = (state_r != ST_IDLE) && avm_waitrequest;
    assign rdv_ok_s    = avm_readdatavalid && (outstanding_r != OUT_W'(0));
    assign start_s     = vid_req && !vid_busy;
    // The write handshake completes in the same cycle the controller takes it.
    assign wr_ready    = wr_accept_s;

    // Next values of the line and flow-control counters.
    always_comb begin
        base_s        = base_r;
        issued_s      = issued_r;
        returned_s    = returned_r;
        busy_s        = vid_busy;
        outstanding_s = outstanding_r;
        starve_s      = starve_r;
        if (start_s) begin
            base_s     = vid_base;
            issued_s   = CNT_W'(0);
            returned_s = CNT_W'(0);
            busy_s     = 1'b1;
        end else begin
            if (rd_accept_s) begin
                issued_s = issued_r + CNT_W'(1);
            end else begin
                issued_s = issued_r;
            end
            if (vid_busy && rdv_ok_s) begin
                returned_s = returned_r + CNT_W'(1);
                busy_s     = (returned_r != LAST_C);
            end else begin
                returned_s = returned_r;
            end
        end
        case ({rd_accept_s, rdv_ok_s})
            2'b10:   outstanding_s = outstanding_r + OUT_W'(1);
            2'b01:   outstanding_s = outstanding_r - OUT_W'(1);
            default: outstanding_s = outstanding_r;
        endcase
        if (!wr_valid || wr_accept_s) begin
            starve_s = STV_W'(0);
        end else if (rd_accept_s && (starve_r != STV_C)) begin
            starve_s = starve_r + STV_W'(1);
        end else begin
            starve_s = starve_r;
        end
    end

    // Eligibility is judged on post-update counters so commands can run back to back;
    // wr_valid is stale during its own acceptance cycle and is masked there.
    assign rd_elig_s = busy_s && (issued_s < LINE_C) && (outstanding_s < OUT_C);
    assign wr_elig_s = wr_valid && !wr_accept_s;

    // Next-state: a held command stays put, otherwise arbitrate.
    always_comb begin
        state_s = state_r;
        if (held_s) begin
            state_s = state_r;
        end else if (wr_elig_s && (!rd_elig_s || (starve_s == STV_C))) begin
            state_s = ST_WR;
        end else if (rd_elig_s) begin
            state_s = ST_VID;
        end else begin
            state_s = ST_IDLE;
        end
    end

    // Next command outputs; payload only changes when a new command is chosen.
    always_comb begin
        read_s  = 1'b0;
        write_s = 1'b0;
        addr_s  = avm_address;
        wdata_s = avm_writedata;
        case (state_s)
            ST_VID: begin
                read_s = 1'b1;
                if (!held_s) begin
                    addr_s = base_s + ADDR_W'(issued_s);
                end else begin
                    addr_s = avm_address;
                end
            end
            ST_WR: begin
                write_s = 1'b1;
                if (!held_s) begin
                    addr_s  = wr_addr;
                    wdata_s = wr_data;
                end else begin
                    addr_s  = avm_address;
                    wdata_s = avm_writedata;
                end
            end
            default: begin
                read_s  = 1'b0;
                write_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            base_r        <= {ADDR_W{1'b0}};
            issued_r      <= {CNT_W{1'b0}};
            returned_r    <= {CNT_W{1'b0}};
            outstanding_r <= {OUT_W{1'b0}};
            starve_r      <= {STV_W{1'b0}};
            vid_busy      <= 1'b0;
        end else begin
            base_r        <= base_s;
            issued_r      <= issued_s;
            returned_r    <= returned_s;
            outstanding_r <= outstanding_s;
            starve_r      <= starve_s;
            vid_busy      <= busy_s;
        end
    end

    // Registered Avalon command, video return path and sticky error.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= {ADDR_W{1'b0}};
            avm_writedata <= {DATA_W{1'b0}};
            vid_valid     <= 1'b0;
            vid_data      <= {DATA_W{1'b0}};
            err           <= 1'b0;
        end else begin
            avm_read      <= read_s;
            avm_write     <= write_s;
            avm_address   <= addr_s;
            avm_writedata <= wdata_s;
            vid_valid     <= rdv_ok_s;
            vid_data      <= rdv_ok_s ? avm_readdata : vid_data;
            err           <= err | (avm_readdatavalid && (outstanding_r == OUT_W'(0)));
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: small line/outstanding/starve parameters, an
// Avalon slave model returning data two cycles after each accepted read.
module tb_fb_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vid_req;
    logic [AW-1:0] vid_base;
    logic          vid_busy;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [40:0] cmd_log[$];
    logic [15:0] vid_log[$];
    int          wr_ready_cnt = 0;
    int          both_cnt = 0;
    int          out_model = 0;
    int          max_out = 0;
    logic        s0 = 1'b0, s1 = 1'b0;
    logic [15:0] d0 = 16'h0000, d1 = 16'h0000;
    logic        inject;
    logic [15:0] inj_data;

    fb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(4), .MAX_OUT(2), .STARVE_MAX(2)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .vid_req(vid_req), .vid_base(vid_base), .vid_busy(vid_busy),
        .vid_data(vid_data), .vid_valid(vid_valid),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input logic [23:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Command/response logger and read-latency pipeline of the slave model.
    always @(posedge clk) begin
        if (!rst_n) begin
            s0 <= 1'b0; s1 <= 1'b0; d0 <= 16'h0000; d1 <= 16'h0000;
            out_model <= 0;
        end else begin
            if (avm_read && !avm_waitrequest) cmd_log.push_back({1'b0, avm_address, 16'h0000});
            if (avm_write && !avm_waitrequest) cmd_log.push_back({1'b1, avm_address, avm_writedata});
            if (wr_ready) wr_ready_cnt <= wr_ready_cnt + 1;
            if (avm_read && avm_write) both_cnt <= both_cnt + 1;
            if (vid_valid) vid_log.push_back(vid_data);
            if ((avm_read && !avm_waitrequest) && !(avm_readdatavalid && out_model > 0))
                out_model <= out_model + 1;
            else if (!(avm_read && !avm_waitrequest) && avm_readdatavalid && out_model > 0)
                out_model <= out_model - 1;
            if (out_model > max_out) max_out <= out_model;
            s1 <= s0; d1 <= d0;
            s0 <= avm_read && !avm_waitrequest;
            d0 <= word_of(avm_address);
        end
    end

    // Slave response drive, mid-cycle.
    always @(negedge clk) begin
        avm_readdatavalid <= rst_n && (s1 || inject);
        avm_readdata      <= s1 ? d1 : (inject ? inj_data : 16'h0000);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_line(input logic [23:0] b);
        vid_req  = 1'b1;
        vid_base = b;
        @(negedge clk);
        vid_req  = 1'b0;
    endtask

    task automatic wait_line(output int nvalid, output logic busy_at_4th, output logic timeout);
        logic wr_seen;
        wr_seen     = 1'b0;
        nvalid      = 0;
        busy_at_4th = 1'b1;
        timeout     = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (wr_seen) wr_valid = 1'b0;
            if (wr_ready) wr_seen = 1'b1;
            if (vid_valid) begin
                nvalid++;
                if (nvalid == 4) busy_at_4th = vid_busy;
            end
            if (!vid_busy) begin
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_line(input string tag, input logic [23:0] b, input int ci, input int vi);
        logic [23:0] ea;
        check($sformatf("%s_nreads", tag), 64'(cmd_log.size() - ci), 64'd4);
        check($sformatf("%s_nwords", tag), 64'(vid_log.size() - vi), 64'd4);
        for (int k = 0; k < 4; k++) begin
            ea = b + 24'(k);
            check($sformatf("%s_addr%0d", tag, k), 64'(cmd_log[ci + k]), 64'({1'b0, ea, 16'h0000}));
            check($sformatf("%s_data%0d", tag, k), 64'(vid_log[vi + k]), 64'(word_of(ea)));
        end
    endtask

    initial begin
        int   ci, vi, nv, wc;
        logic b4, to;

        rst_n = 1'b0; vid_req = 1'b0; vid_base = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        avm_waitrequest = 1'b0; inject = 1'b0; inj_data = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(vid_busy), 64'd0);
        check("rst_valid", 64'(vid_valid), 64'd0);
        check("rst_read", 64'(avm_read), 64'd0);
        check("rst_write", 64'(avm_write), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain line fetch.
        ci = cmd_log.size(); vi = vid_log.size();
        start_line(24'h000100);
        wait_line(nv, b4, to);
        check("l1_timeout", 64'(to), 64'd0);
        check("l1_nvalid", 64'(nv), 64'd4);
        check("l1_busy_at_last", 64'(b4), 64'd0);
        check_line("l1", 24'h000100, ci, vi);

        // First read stalled three cycles by waitrequest.
        ci = cmd_log.size(); vi = vid_log.size();
        avm_waitrequest = 1'b1;
        start_line(24'h000100);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("ws_read_c%0d", c), 64'(avm_read), 64'd1);
            check($sformatf("ws_addr_c%0d", c), 64'(avm_address), 64'h100);
            check($sformatf("ws_write_c%0d", c), 64'(avm_write), 64'd0);
            check($sformatf("ws_noacc_c%0d", c), 64'(cmd_log.size() - ci), 64'd0);
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        check("ws_read_c3", 64'(avm_read), 64'd1);
        check("ws_addr_c3", 64'(avm_address), 64'h100);
        wait_line(nv, b4, to);
        check("ws_timeout", 64'(to), 64'd0);
        check_line("ws", 24'h000100, ci, vi);

        // Pending write during a line: starvation bound forces it after 2 reads.
        ci = cmd_log.size(); vi = vid_log.size(); wc = wr_ready_cnt;
        wr_addr = 24'h000020; wr_data = 16'hBEEF; wr_valid = 1'b1;
        start_line(24'h000100);
        wait_line(nv, b4, to);
        check("st_timeout", 64'(to), 64'd0);
        check("st_ncmd", 64'(cmd_log.size() - ci), 64'd5);
        check("st_cmd0", 64'(cmd_log[ci + 0]), 64'({1'b0, 24'h000100, 16'h0000}));
        check("st_cmd1", 64'(cmd_log[ci + 1]), 64'({1'b0, 24'h000101, 16'h0000}));
        check("st_cmd2", 64'(cmd_log[ci + 2]), 64'({1'b1, 24'h000020, 16'hBEEF}));
        check("st_cmd3", 64'(cmd_log[ci + 3]), 64'({1'b0, 24'h000102, 16'h0000}));
        check("st_cmd4", 64'(cmd_log[ci + 4]), 64'({1'b0, 24'h000103, 16'h0000}));
        check("st_wr_ready_pulses", 64'(wr_ready_cnt - wc), 64'd1);
        check("st_nwords", 64'(vid_log.size() - vi), 64'd4);
        check("st_data3", 64'(vid_log[vi + 3]), 64'(word_of(24'h000103)));

        // Address wrap at the top of the 24-bit space.
        ci = cmd_log.size(); vi = vid_log.size();
        start_line(24'hFFFFFE);
        wait_line(nv, b4, to);
        check("wr_timeout", 64'(to), 64'd0);
        check_line("wrap", 24'hFFFFFE, ci, vi);

        // Spurious readdatavalid with nothing outstanding.
        check("sp_err_before", 64'(err), 64'd0);
        vi = vid_log.size();
        @(posedge clk);
        inject = 1'b1; inj_data = 16'h1234;
        @(posedge clk);
        inject = 1'b0;
        @(negedge clk);
        check("sp_err_set", 64'(err), 64'd1);
        check("sp_valid", 64'(vid_valid), 64'd0);
        repeat (3) @(negedge clk);
        check("sp_err_sticky", 64'(err), 64'd1);
        check("sp_no_word", 64'(vid_log.size() - vi), 64'd0);

        // Reset in the middle of a line, then a clean fetch right after release.
        ci = cmd_log.size();
        to = 1'b1;
        start_line(24'h000300);
        for (int i = 0; i < 20; i++) begin
            if (cmd_log.size() - ci >= 2) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("mr_two_reads", 64'(to), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mr_busy", 64'(vid_busy), 64'd0);
        check("mr_err", 64'(err), 64'd0);
        check("mr_read", 64'(avm_read), 64'd0);
        check("mr_addr", 64'(avm_address), 64'd0);
        check("mr_wdata", 64'(avm_writedata), 64'd0);
        check("mr_vdata", 64'(vid_data), 64'd0);
        check("mr_valid", 64'(vid_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ci = cmd_log.size(); vi = vid_log.size();
        start_line(24'h000200);
        wait_line(nv, b4, to);
        check("ar_timeout", 64'(to), 64'd0);
        check_line("ar", 24'h000200, ci, vi);

        check("max_outstanding_le2", 64'(max_out <= 2), 64'd1);
        check("never_both_cmds", 64'(both_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
